// File: rtl/prefetch_queue_if.sv
// Decoder/memory-facing signal bundle of the instruction prefetch queue.
// master = the queue itself, slave = memory port plus decoder.
interface prefetch_queue_if;
    logic        flush;
    logic [15:0] flush_adr;
    logic        mem_req;
    logic [15:0] mem_adr;
    logic        mem_ack;
    logic [15:0] mem_din;
    logic        nxi;
    logic [31:0] cmd;
    logic        rqi;
    logic [15:0] cur_ip;

    modport master (
        input  flush, flush_adr, mem_ack, mem_din, rqi,
        output mem_req, mem_adr, nxi, cmd, cur_ip
    );

    modport slave (
        output flush, flush_adr, mem_ack, mem_din, rqi,
        input  mem_req, mem_adr, nxi, cmd, cur_ip
    );
endinterface

// File: rtl/prefetch_queue.sv
// 8-byte instruction prefetch queue fetching 16-bit words, presenting a 32-bit head window.
// Optional macro PQ_LENDEC_EN enables the 2/4-byte length decoder; otherwise length is fixed at 4.
module prefetch_queue #(
    parameter logic [15:0] RESET_IP = 16'h0000
) (
    input  logic             clk,
    input  logic             rst_n,
    prefetch_queue_if.master pq
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        STALE = 2'd2
    } state_t;

    state_t      state_r;
    logic [7:0]  bytes_r [0:7];
    logic [2:0]  head_r;
    logic [2:0]  tail_r;
    logic [3:0]  count_r;
    logic [15:0] fetch_adr_r;
    logic        skip_r;
    logic [15:0] cur_ip_r;
    logic        mem_req_r;
    logic [15:0] mem_adr_r;

    logic [3:0]  len_s;
    logic        nxi_s;
    logic        consume_s;
    logic        accept_s;
    logic [3:0]  push_s;
    logic [3:0]  pop_s;

`ifdef PQ_LENDEC_EN
    // Length decode from the head opcode's upper nibble
    always_comb begin
        if (bytes_r[head_r][7:4] >= 4'hC) begin
            len_s = 4'd2;
        end else begin
            len_s = 4'd4;
        end
    end
`else
    assign len_s = 4'd4;
`endif

    assign nxi_s     = (count_r >= len_s);
    assign consume_s = pq.rqi && nxi_s && !pq.flush;
    assign accept_s  = (state_r == BUSY) && pq.mem_ack && !pq.flush;

    // Number of bytes entering and leaving the queue this cycle
    always_comb begin
        push_s = 4'd0;
        pop_s  = 4'd0;
        if (accept_s) begin
            if (skip_r) begin
                push_s = 4'd1;
            end else begin
                push_s = 4'd2;
            end
        end else begin
            push_s = 4'd0;
        end
        if (consume_s) begin
            pop_s = len_s;
        end else begin
            pop_s = 4'd0;
        end
    end

    // Byte storage; an odd restart address drops the high byte of the first word
    always_ff @(posedge clk) begin
        if (accept_s) begin
            if (skip_r) begin
                bytes_r[tail_r] <= pq.mem_din[7:0];
            end else begin
                bytes_r[tail_r]        <= pq.mem_din[15:8];
                bytes_r[tail_r + 3'd1] <= pq.mem_din[7:0];
            end
        end
    end

    // Queue pointers, instruction pointer and fetch FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            head_r      <= 3'd0;
            tail_r      <= 3'd0;
            count_r     <= 4'd0;
            fetch_adr_r <= RESET_IP;
            skip_r      <= 1'b0;
            cur_ip_r    <= RESET_IP;
            mem_req_r   <= 1'b0;
            mem_adr_r   <= RESET_IP;
        end else if (pq.flush) begin
            head_r      <= 3'd0;
            tail_r      <= 3'd0;
            count_r     <= 4'd0;
            cur_ip_r    <= pq.flush_adr;
            fetch_adr_r <= {pq.flush_adr[15:1], 1'b0};
            skip_r      <= pq.flush_adr[0];
            // An in-flight request must still be completed by memory, its data is dropped
            case (state_r)
                IDLE: begin
                    state_r   <= IDLE;
                    mem_req_r <= 1'b0;
                end
                BUSY, STALE: begin
                    if (pq.mem_ack) begin
                        state_r   <= IDLE;
                        mem_req_r <= 1'b0;
                    end else begin
                        state_r   <= STALE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    mem_req_r <= 1'b0;
                end
            endcase
        end else begin
            count_r <= count_r + push_s - pop_s;
            if (consume_s) begin
                head_r   <= head_r + len_s[2:0];
                cur_ip_r <= cur_ip_r + {12'd0, len_s};
            end
            if (accept_s) begin
                tail_r      <= tail_r + push_s[2:0];
                skip_r      <= 1'b0;
                fetch_adr_r <= fetch_adr_r + 16'd2;
            end
            case (state_r)
                IDLE: begin
                    if (count_r <= 4'd6) begin
                        mem_req_r <= 1'b1;
                        mem_adr_r <= fetch_adr_r;
                        state_r   <= BUSY;
                    end else begin
                        mem_req_r <= 1'b0;
                    end
                end
                BUSY, STALE: begin
                    if (pq.mem_ack) begin
                        mem_req_r <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    mem_req_r <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    assign pq.mem_req = mem_req_r;
    assign pq.mem_adr = mem_adr_r;
    assign pq.cur_ip  = cur_ip_r;
    assign pq.nxi     = nxi_s;
    assign pq.cmd     = {bytes_r[head_r], bytes_r[head_r + 3'd1],
                         bytes_r[head_r + 3'd2], bytes_r[head_r + 3'd3]};

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue: zero-wait memory model, fixed-length and
// (with PQ_LENDEC_EN) variable-length expectations, flush and async reset.
module tb_prefetch_queue;

    logic clk = 1'b0;
    logic rst_n;
    logic hold_ack;
    logic [7:0] mem [0:65535];
    int checks = 0;
    int errors = 0;

    prefetch_queue_if pq ();

    prefetch_queue #(.RESET_IP(16'h0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pq    (pq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then let the memory answer any pending request
    task automatic tick();
        @(posedge clk);
        #2;
        pq.mem_ack = pq.mem_req && !hold_ack;
        pq.mem_din = {mem[pq.mem_adr], mem[pq.mem_adr + 16'd1]};
    endtask

    task automatic set_bytes(input logic [15:0] adr, input logic [7:0] b0, input logic [7:0] b1);
        mem[adr]         = b0;
        mem[adr + 16'd1] = b1;
    endtask

    initial begin
        rst_n        = 1'b0;
        hold_ack     = 1'b0;
        pq.flush     = 1'b0;
        pq.flush_adr = 16'h0000;
        pq.rqi       = 1'b0;
        pq.mem_ack   = 1'b0;
        pq.mem_din   = 16'h0000;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        set_bytes(16'h0000, 8'h11, 8'h22);
        set_bytes(16'h0002, 8'h33, 8'h44);
        set_bytes(16'h0004, 8'h55, 8'h66);
        set_bytes(16'h0006, 8'h77, 8'h88);
        set_bytes(16'h0008, 8'h99, 8'hAA);
        set_bytes(16'h000A, 8'hDE, 8'hAD);
        set_bytes(16'h0102, 8'hEE, 8'h5A);
        set_bytes(16'h0104, 8'h01, 8'h02);
        set_bytes(16'h0106, 8'h03, 8'h04);
        set_bytes(16'h0200, 8'hC1, 8'h02);
        set_bytes(16'h0202, 8'h12, 8'h34);
        set_bytes(16'h0204, 8'h56, 8'h78);
        set_bytes(16'h0206, 8'h9A, 8'hBC);
        set_bytes(16'h0208, 8'hDE, 8'hF0);

        tick();
        tick();
        chk("rst_mem_req", 32'(pq.mem_req), 32'd0);
        chk("rst_nxi",     32'(pq.nxi),     32'd0);
        chk("rst_mem_adr", 32'(pq.mem_adr), 32'h0000);
        chk("rst_cur_ip",  32'(pq.cur_ip),  32'h0000);
        rst_n = 1'b1;

        tick();
        chk("t1_mem_req", 32'(pq.mem_req), 32'd1);
        chk("t1_mem_adr", 32'(pq.mem_adr), 32'h0000);
        tick();
        chk("t2_mem_req", 32'(pq.mem_req), 32'd0);
        chk("t2_nxi",     32'(pq.nxi),     32'd0);
        tick();
        chk("t3_mem_adr", 32'(pq.mem_adr), 32'h0002);
        tick();
        chk("t4_nxi",    32'(pq.nxi),    32'd1);
        chk("t4_cmd",    pq.cmd,         32'h11223344);
        chk("t4_cur_ip", 32'(pq.cur_ip), 32'h0000);

        // Queue fills to 8 bytes and fetching stops
        repeat (4) tick();
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("full_mem_req_low", 32'(pq.mem_req), 32'd0);
        end
        chk("full_cmd", pq.cmd, 32'h11223344);

        chk("nxi_before_rqi1", 32'(pq.nxi), 32'd1);
        pq.rqi = 1'b1;
        tick();
        pq.rqi = 1'b0;
        chk("c1_cur_ip",  32'(pq.cur_ip),  32'h0004);
        chk("c1_cmd",     pq.cmd,          32'h55667788);
        chk("c1_mem_req", 32'(pq.mem_req), 32'd0);
        tick();
        chk("refetch_mem_req", 32'(pq.mem_req), 32'd1);
        chk("refetch_mem_adr", 32'(pq.mem_adr), 32'h0008);

        // Ack and consume in the same cycle: 4 + 2 - 4 = 2 bytes left
        chk("nxi_before_rqi2", 32'(pq.nxi), 32'd1);
        pq.rqi = 1'b1;
        tick();
        pq.rqi = 1'b0;
        chk("ackrqi_cmd_hi",  32'(pq.cmd[31:16]), 32'h99AA);
        chk("ackrqi_nxi",     32'(pq.nxi),        32'd0);
        chk("ackrqi_cur_ip",  32'(pq.cur_ip),     32'h0008);
        chk("ackrqi_mem_req", 32'(pq.mem_req),    32'd0);

        // Flush to an odd address while a request is outstanding
        hold_ack = 1'b1;
        tick();
        chk("busy_mem_req", 32'(pq.mem_req), 32'd1);
        chk("busy_mem_adr", 32'(pq.mem_adr), 32'h000A);
        pq.flush     = 1'b1;
        pq.flush_adr = 16'h0103;
        tick();
        pq.flush = 1'b0;
        chk("stale_mem_req", 32'(pq.mem_req), 32'd1);
        chk("stale_mem_adr", 32'(pq.mem_adr), 32'h000A);
        chk("stale_cur_ip",  32'(pq.cur_ip),  32'h0103);
        chk("stale_nxi",     32'(pq.nxi),     32'd0);
        tick();
        chk("stale_hold_adr", 32'(pq.mem_adr), 32'h000A);
        hold_ack = 1'b0;
        tick();
        chk("stale_ack_req", 32'(pq.mem_req), 32'd1);
        tick();
        chk("stale_done_req", 32'(pq.mem_req), 32'd0);
        chk("stale_done_nxi", 32'(pq.nxi),     32'd0);
        tick();
        chk("odd_mem_req", 32'(pq.mem_req), 32'd1);
        chk("odd_mem_adr", 32'(pq.mem_adr), 32'h0102);
        tick();
        chk("odd_nxi",     32'(pq.nxi),       32'd0);
        chk("odd_byte",    32'(pq.cmd[31:24]), 32'h5A);
        chk("odd_cur_ip",  32'(pq.cur_ip),    32'h0103);
        repeat (2) tick();
        chk("odd3_nxi", 32'(pq.nxi), 32'd0);
        repeat (2) tick();
        chk("odd5_nxi", 32'(pq.nxi), 32'd1);
        chk("odd5_cmd", pq.cmd,      32'h5A010203);

        // Length decode: head byte 0xC1
        pq.flush     = 1'b1;
        pq.flush_adr = 16'h0200;
        tick();
        pq.flush = 1'b0;
        chk("fl2_mem_req", 32'(pq.mem_req), 32'd0);
        chk("fl2_cur_ip",  32'(pq.cur_ip),  32'h0200);
        chk("fl2_nxi",     32'(pq.nxi),     32'd0);
        tick();
        chk("fl2_mem_adr", 32'(pq.mem_adr), 32'h0200);
        tick();
        chk("len_cmd_hi", 32'(pq.cmd[31:16]), 32'hC102);
`ifdef PQ_LENDEC_EN
        chk("len2_nxi_at2", 32'(pq.nxi), 32'd1);
`else
        chk("len4_nxi_at2", 32'(pq.nxi), 32'd0);
`endif
        repeat (2) tick();
        chk("len_nxi_at4", 32'(pq.nxi),    32'd1);
        chk("len_cmd",     pq.cmd,         32'hC1021234);
        chk("len_cur_ip",  32'(pq.cur_ip), 32'h0200);
        pq.rqi = 1'b1;
        tick();
        pq.rqi = 1'b0;
        chk("len_c_nxi", 32'(pq.nxi), 32'd0);
`ifdef PQ_LENDEC_EN
        chk("len2_c_cur_ip", 32'(pq.cur_ip),     32'h0202);
        chk("len2_c_cmd_hi", 32'(pq.cmd[31:16]), 32'h1234);
        tick();
        chk("len2_n_nxi", 32'(pq.nxi), 32'd1);
        chk("len2_n_cmd", pq.cmd,      32'h12345678);
        pq.rqi = 1'b1;
        tick();
        pq.rqi = 1'b0;
        chk("len2_n_cur_ip", 32'(pq.cur_ip), 32'h0206);
        chk("len2_n_cnxi",   32'(pq.nxi),    32'd0);
`else
        chk("len4_c_cur_ip", 32'(pq.cur_ip), 32'h0204);
        tick();
        chk("len4_n_nxi",    32'(pq.nxi),        32'd0);
        chk("len4_n_cmd_hi", 32'(pq.cmd[31:16]), 32'h5678);
        repeat (2) tick();
        chk("len4_m_nxi",    32'(pq.nxi),    32'd1);
        chk("len4_m_cmd",    pq.cmd,         32'h56789ABC);
        chk("len4_m_cur_ip", 32'(pq.cur_ip), 32'h0204);
        pq.rqi = 1'b1;
        tick();
        pq.rqi = 1'b0;
        chk("len4_m_c_cur_ip", 32'(pq.cur_ip), 32'h0208);
`endif
        chk("pre_rst_mem_req", 32'(pq.mem_req), 32'd1);

        // Asynchronous reset mid-request drops mem_req without a clock edge
        rst_n = 1'b0;
        #1;
        chk("async_rst_mem_req", 32'(pq.mem_req), 32'd0);
        chk("async_rst_nxi",     32'(pq.nxi),     32'd0);
        chk("async_rst_cur_ip",  32'(pq.cur_ip),  32'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
